// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// master drives requests/data; slave (the FIFO) drives data, status and errors.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en_i;
  logic [DATA_W-1:0] data_i;
  logic              full_o;
  logic              almost_full_o;
  logic              rd_en_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              empty_o;
  logic              almost_empty_o;
  logic [CW-1:0]     count_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              clr_err_i;

  modport master (
    output wr_en_i, data_i, rd_en_i, clr_err_i,
    input  full_o, almost_full_o, data_o, valid_o,
    input  empty_o, almost_empty_o, count_o,
    input  overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, data_i, rd_en_i, clr_err_i,
    output full_o, almost_full_o, data_o, valid_o,
    output empty_o, almost_empty_o, count_o,
    output overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: standard or FWFT read, count, sticky errors.
// Ports: clk, rst_n (async active-low), bus (slave side of sync_fifo_param_if).
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range");
  end
  if (DATA_W < 1) begin : g_bad_w
    $error("sync_fifo_param: DATA_W must be >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] dout;
  logic              vld;
  logic              ovf;
  logic              unf;

  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic              mem_re;
  logic              byp;
  logic [CW-1:0]     mem_cnt;

  assign full  = (count == DEPTH_C);
  assign empty = (FWFT != 0) ? !vld : (count == '0);

  // In FWFT mode the output register holds the head word, so the array
  // only holds count - vld words; writes bypass it when the head slot
  // is (or is about to become) free with nothing queued behind it.
  always_comb begin
    wr_acc  = bus.wr_en_i && !full;
    rd_acc  = bus.rd_en_i && !empty;
    mem_cnt = count - {{AW{1'b0}}, vld};
    byp     = 1'b0;
    mem_we  = wr_acc;
    mem_re  = rd_acc;
    if (FWFT != 0) begin
      byp    = wr_acc && (!vld || (rd_acc && mem_cnt == '0));
      mem_we = wr_acc && !byp;
      mem_re = rd_acc && (mem_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
      vld   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (mem_we) wptr <= wptr + AW'(1);
      if (mem_re) rptr <= rptr + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      ovf <= (ovf && !bus.clr_err_i) || (bus.wr_en_i && full);
      unf <= (unf && !bus.clr_err_i) || (bus.rd_en_i && empty);
      if (FWFT == 0) begin
        vld <= rd_acc;
        if (rd_acc) dout <= mem[rptr];
      end else begin
        if (byp) begin
          dout <= bus.data_i;
          vld  <= 1'b1;
        end else if (mem_re) begin
          dout <= mem[rptr];
        end else if (rd_acc) begin
          vld  <= 1'b0;
        end
      end
    end
  end

  assign bus.full_o         = full;
  assign bus.almost_full_o  = (count >= AF_C);
  assign bus.almost_empty_o = (count <= AE_C);
  assign bus.empty_o        = empty;
  assign bus.count_o        = count;
  assign bus.data_o         = dout;
  assign bus.valid_o        = vld;
  assign bus.overflow_o     = ovf;
  assign bus.underflow_o    = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances on shared stimulus,
// queue model compared every cycle plus directed literal expectations.
module tb_sync_fifo_param;
  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr = 1'b0;
  logic rd = 1'b0;
  logic clr = 1'b0;
  logic [DW-1:0] din = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_s ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_f ();

  assign bus_s.wr_en_i   = wr;
  assign bus_s.rd_en_i   = rd;
  assign bus_s.clr_err_i = clr;
  assign bus_s.data_i    = din;
  assign bus_f.wr_en_i   = wr;
  assign bus_f.rd_en_i   = rd;
  assign bus_f.clr_err_i = clr;
  assign bus_f.data_i    = din;

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF),
    .AE_THRESH(AE), .FWFT(0)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF),
    .AE_THRESH(AE), .FWFT(1)
  ) u_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f)
  );

  // Behavioural model: a queue of held words per instance.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] es_data;
  logic          es_valid;
  logic          ovs, uns, ovf, unf;
  logic          pre_e, pre_f;
  logic [DW-1:0] popped;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s.delete();
      q_f.delete();
      es_data  = '0;
      es_valid = 1'b0;
      ovs = 1'b0; uns = 1'b0;
      ovf = 1'b0; unf = 1'b0;
    end else begin
      pre_e = (q_s.size() == 0);
      pre_f = (q_s.size() == DP);
      ovs = (ovs && !clr) || (wr && pre_f);
      uns = (uns && !clr) || (rd && pre_e);
      es_valid = 1'b0;
      if (rd && !pre_e) begin
        es_data  = q_s.pop_front();
        es_valid = 1'b1;
      end
      if (wr && !pre_f) q_s.push_back(din);
      pre_e = (q_f.size() == 0);
      pre_f = (q_f.size() == DP);
      ovf = (ovf && !clr) || (wr && pre_f);
      unf = (unf && !clr) || (rd && pre_e);
      if (rd && !pre_e) popped = q_f.pop_front();
      if (wr && !pre_f) q_f.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_count", 32'(bus_s.count_o), 32'(q_s.size()));
      chk("s_full", 32'(bus_s.full_o), 32'(q_s.size() == DP));
      chk("s_empty", 32'(bus_s.empty_o), 32'(q_s.size() == 0));
      chk("s_af", 32'(bus_s.almost_full_o), 32'(q_s.size() >= AF));
      chk("s_ae", 32'(bus_s.almost_empty_o), 32'(q_s.size() <= AE));
      chk("s_valid", 32'(bus_s.valid_o), 32'(es_valid));
      chk("s_data", 32'(bus_s.data_o), 32'(es_data));
      chk("s_ovf", 32'(bus_s.overflow_o), 32'(ovs));
      chk("s_unf", 32'(bus_s.underflow_o), 32'(uns));
      chk("f_count", 32'(bus_f.count_o), 32'(q_f.size()));
      chk("f_full", 32'(bus_f.full_o), 32'(q_f.size() == DP));
      chk("f_empty", 32'(bus_f.empty_o), 32'(q_f.size() == 0));
      chk("f_valid", 32'(bus_f.valid_o), 32'(q_f.size() != 0));
      if (q_f.size() != 0)
        chk("f_data", 32'(bus_f.data_o), 32'(q_f[0]));
      chk("f_af", 32'(bus_f.almost_full_o), 32'(q_f.size() >= AF));
      chk("f_ae", 32'(bus_f.almost_empty_o), 32'(q_f.size() <= AE));
      chk("f_ovf", 32'(bus_f.overflow_o), 32'(ovf));
      chk("f_unf", 32'(bus_f.underflow_o), 32'(unf));
    end
  end

  // Apply one cycle of inputs; returns just after the edge that used them.
  task automatic cyc(input logic w, input logic [DW-1:0] d,
                     input logic r, input logic c);
    @(negedge clk);
    wr = w; din = d; rd = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_s_count"}, 32'(bus_s.count_o), 0);
    chk({tag, "_s_empty"}, 32'(bus_s.empty_o), 1);
    chk({tag, "_s_ae"}, 32'(bus_s.almost_empty_o), 1);
    chk({tag, "_s_full"}, 32'(bus_s.full_o), 0);
    chk({tag, "_s_af"}, 32'(bus_s.almost_full_o), 0);
    chk({tag, "_s_data"}, 32'(bus_s.data_o), 0);
    chk({tag, "_s_valid"}, 32'(bus_s.valid_o), 0);
    chk({tag, "_s_ovf"}, 32'(bus_s.overflow_o), 0);
    chk({tag, "_s_unf"}, 32'(bus_s.underflow_o), 0);
    chk({tag, "_f_count"}, 32'(bus_f.count_o), 0);
    chk({tag, "_f_valid"}, 32'(bus_f.valid_o), 0);
    chk({tag, "_f_empty"}, 32'(bus_f.empty_o), 1);
    chk({tag, "_f_data"}, 32'(bus_f.data_o), 0);
  endtask

  initial begin
    #12;
    reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then one dropped write.
    for (int i = 0; i < DP; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 12) chk("t1_af_13", 32'(bus_s.almost_full_o), 0);
      if (i == 13) chk("t1_af_14", 32'(bus_s.almost_full_o), 1);
      if (i == 14) chk("t1_full_15", 32'(bus_s.full_o), 0);
    end
    chk("t1_full", 32'(bus_s.full_o), 1);
    chk("t1_count", 32'(bus_s.count_o), 16);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t1_ovf", 32'(bus_s.overflow_o), 1);
    chk("t1_count17", 32'(bus_s.count_o), 16);
    chk("t1_f_head", 32'(bus_f.data_o), 8'h00);

    // Drain with one extra read.
    for (int i = 0; i < DP + 1; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      if (i < DP) begin
        chk("t2_valid", 32'(bus_s.valid_o), 1);
        chk("t2_data", 32'(bus_s.data_o), 32'(i));
      end
      if (i == DP - 1) chk("t2_empty", 32'(bus_s.empty_o), 1);
    end
    chk("t2_valid17", 32'(bus_s.valid_o), 0);
    chk("t2_hold", 32'(bus_s.data_o), 8'h0F);
    chk("t2_unf", 32'(bus_s.underflow_o), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t2_clr_ovf", 32'(bus_s.overflow_o), 0);
    chk("t2_clr_unf", 32'(bus_s.underflow_o), 0);

    // FWFT fall-through and pops.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("t4_valid", 32'(bus_f.valid_o), 1);
    chk("t4_data", 32'(bus_f.data_o), 8'h3C);
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t4_data2", 32'(bus_f.data_o), 8'h3C);
    chk("t4_count2", 32'(bus_f.count_o), 2);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_pop1", 32'(bus_f.data_o), 8'h5A);
    chk("t4_s_pop1", 32'(bus_s.data_o), 8'h3C);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_valid0", 32'(bus_f.valid_o), 0);
    chk("t4_empty", 32'(bus_f.empty_o), 1);
    chk("t4_s_pop2", 32'(bus_s.data_o), 8'h5A);

    // Steady state at count 5 with simultaneous read/write.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(8'h85 + i), 1'b1, 1'b0);
      chk("t3_count", 32'(bus_s.count_o), 5);
      chk("t3_data", 32'(bus_s.data_o), 32'(8'h80 + i));
      chk("t3_f_head", 32'(bus_f.data_o), 32'(8'h81 + i));
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t3_tail", 32'(bus_s.data_o), 8'hAC);
    chk("t3_empty", 32'(bus_s.empty_o), 1);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    chk("t5_count9", 32'(bus_s.count_o), 9);
    cyc(1'b0, '0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    reset_vals("t5");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t5_f_data", 32'(bus_f.data_o), 8'h11);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t5_s_data", 32'(bus_s.data_o), 8'h11);
    chk("t5_count0", 32'(bus_s.count_o), 0);

    // Error clear, and clear coinciding with a new overflow.
    for (int i = 0; i < DP; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t6_ovf", 32'(bus_s.overflow_o), 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t6_clr", 32'(bus_s.overflow_o), 0);
    cyc(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("t6_keep", 32'(bus_s.overflow_o), 1);
    chk("t6_f_keep", 32'(bus_f.overflow_o), 1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
